agc_stat_accum: RTL

- Downstream of the per-sample AGC scaling DSP stage.
- Consumes the saturated 5-bit outputs, as magnitude plus over/under-threshold flags, for NSAMP parallel samples per clock.
- Over a programmable window it accumulates the sum of squared magnitudes and counts the gt/lt flags.
- Software uses the results to servo the scale and offset registers (RMS and balance estimate).

---
 rtl/agc_stat_accum.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/agc_stat_accum.sv
// AGC statistics accumulator: windowed sum of squared magnitudes and gt/lt flag counts
// over NSAMP parallel lanes, with a fixed three-stage pipeline ahead of the accumulator.
module agc_stat_accum #(
  parameter int unsigned NSAMP       = 8,
  parameter int unsigned ABS_BITS    = 4,
  parameter int unsigned PERIOD_BITS = 24,
  parameter int unsigned SQ_BITS     = 2 * ABS_BITS + $clog2(NSAMP) + PERIOD_BITS,
  parameter int unsigned CNT_BITS    = $clog2(NSAMP) + PERIOD_BITS
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [PERIOD_BITS-1:0]    period_i,
  input  logic                      ack_i,
  input  logic [NSAMP*ABS_BITS-1:0] abs_i,
  input  logic [NSAMP-1:0]          gt_i,
  input  logic [NSAMP-1:0]          lt_i,
  output logic                      running_o,
  output logic                      done_o,
  output logic [SQ_BITS-1:0]        sq_sum_o,
  output logic [CNT_BITS-1:0]       gt_count_o,
  output logic [CNT_BITS-1:0]       lt_count_o
);

  localparam int unsigned SqW   = 2 * ABS_BITS;
  localparam int unsigned LaneW = SqW + $clog2(NSAMP);
  localparam int unsigned PopW  = $clog2(NSAMP) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                         state_q, state_d;
  logic [PERIOD_BITS-1:0]         cnt_q, cnt_d;
  logic [NSAMP*ABS_BITS-1:0]      s1_abs_q, s1_abs_d;
  logic [NSAMP-1:0]               s1_gt_q, s1_gt_d, s1_lt_q, s1_lt_d;
  logic                           s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [NSAMP-1:0][SqW-1:0]      s2_sq_q, s2_sq_d;
  logic [NSAMP-1:0]               s2_gt_q, s2_gt_d, s2_lt_q, s2_lt_d;
  logic                           s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
  logic [LaneW-1:0]               s3_sq_q, s3_sq_d;
  logic [PopW-1:0]                s3_gt_q, s3_gt_d, s3_lt_q, s3_lt_d;
  logic                           s3_vld_q, s3_vld_d, s3_last_q, s3_last_d;
  logic [SQ_BITS-1:0]             acc_sq_q, acc_sq_d, sq_sum_q, sq_sum_d, sq_tot;
  logic [CNT_BITS-1:0]            acc_gt_q, acc_gt_d, gt_cnt_q, gt_cnt_d, gt_tot;
  logic [CNT_BITS-1:0]            acc_lt_q, acc_lt_d, lt_cnt_q, lt_cnt_d, lt_tot;
  logic                           done_q, done_d, running_q, running_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      state_d = StRun;
      cnt_d   = (period_i == '0) ? PERIOD_BITS'(1) : period_i;
    end else begin
      case (state_q)
        StRun: begin
          cnt_d = cnt_q - PERIOD_BITS'(1);
          if (cnt_q == PERIOD_BITS'(1)) state_d = StDrain;
        end
        StDrain: if (s3_vld_q && s3_last_q) state_d = StDone;
        StDone:  if (ack_i) state_d = StIdle;
        default: ;
      endcase
    end
    done_d    = (state_d == StDone);
    running_d = (state_d == StRun) || (state_d == StDrain);
  end

  // A start edge invalidates every in-flight tag so the aborted window contributes nothing.
  always_comb begin
    s1_abs_d  = abs_i;
    s1_gt_d   = gt_i;
    s1_lt_d   = lt_i;
    s1_vld_d  = (state_q == StRun) && !start_i;
    s1_last_d = s1_vld_d && (cnt_q == PERIOD_BITS'(1));

    for (int n = 0; n < NSAMP; n++) begin
      s2_sq_d[n] = SqW'(s1_abs_q[n*ABS_BITS +: ABS_BITS]) *
                   SqW'(s1_abs_q[n*ABS_BITS +: ABS_BITS]);
    end
    s2_gt_d   = s1_gt_q;
    s2_lt_d   = s1_lt_q;
    s2_vld_d  = s1_vld_q && !start_i;
    s2_last_d = s1_last_q;

    s3_sq_d = '0;
    s3_gt_d = '0;
    s3_lt_d = '0;
    for (int n = 0; n < NSAMP; n++) begin
      s3_sq_d = s3_sq_d + LaneW'(s2_sq_q[n]);
      s3_gt_d = s3_gt_d + PopW'(s2_gt_q[n]);
      s3_lt_d = s3_lt_d + PopW'(s2_lt_q[n]);
    end
    s3_vld_d  = s2_vld_q && !start_i;
    s3_last_d = s2_last_q;
  end

  // The final beat goes straight to the result registers so they change only on completion.
  always_comb begin
    sq_tot   = acc_sq_q + SQ_BITS'(s3_sq_q);
    gt_tot   = acc_gt_q + CNT_BITS'(s3_gt_q);
    lt_tot   = acc_lt_q + CNT_BITS'(s3_lt_q);
    acc_sq_d = acc_sq_q;
    acc_gt_d = acc_gt_q;
    acc_lt_d = acc_lt_q;
    sq_sum_d = sq_sum_q;
    gt_cnt_d = gt_cnt_q;
    lt_cnt_d = lt_cnt_q;
    if (start_i) begin
      acc_sq_d = '0;
      acc_gt_d = '0;
      acc_lt_d = '0;
    end else if (s3_vld_q) begin
      if (s3_last_q) begin
        sq_sum_d = sq_tot;
        gt_cnt_d = gt_tot;
        lt_cnt_d = lt_tot;
        acc_sq_d = '0;
        acc_gt_d = '0;
        acc_lt_d = '0;
      end else begin
        acc_sq_d = sq_tot;
        acc_gt_d = gt_tot;
        acc_lt_d = lt_tot;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      s1_abs_q  <= '0;
      s1_gt_q   <= '0;
      s1_lt_q   <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s2_sq_q   <= '0;
      s2_gt_q   <= '0;
      s2_lt_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s3_sq_q   <= '0;
      s3_gt_q   <= '0;
      s3_lt_q   <= '0;
      s3_vld_q  <= 1'b0;
      s3_last_q <= 1'b0;
      acc_sq_q  <= '0;
      acc_gt_q  <= '0;
      acc_lt_q  <= '0;
      sq_sum_q  <= '0;
      gt_cnt_q  <= '0;
      lt_cnt_q  <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_abs_q  <= s1_abs_d;
      s1_gt_q   <= s1_gt_d;
      s1_lt_q   <= s1_lt_d;
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s2_sq_q   <= s2_sq_d;
      s2_gt_q   <= s2_gt_d;
      s2_lt_q   <= s2_lt_d;
      s2_vld_q  <= s2_vld_d;
      s2_last_q <= s2_last_d;
      s3_sq_q   <= s3_sq_d;
      s3_gt_q   <= s3_gt_d;
      s3_lt_q   <= s3_lt_d;
      s3_vld_q  <= s3_vld_d;
      s3_last_q <= s3_last_d;
      acc_sq_q  <= acc_sq_d;
      acc_gt_q  <= acc_gt_d;
      acc_lt_q  <= acc_lt_d;
      sq_sum_q  <= sq_sum_d;
      gt_cnt_q  <= gt_cnt_d;
      lt_cnt_q  <= lt_cnt_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign running_o  = running_q;
  assign done_o     = done_q;
  assign sq_sum_o   = sq_sum_q;
  assign gt_count_o = gt_cnt_q;
  assign lt_count_o = lt_cnt_q;

endmodule
